// File: rtl/data_skid_pkg.sv
// data_skid_pkg
//   Shared definitions for the data skid stage: the occupancy state
//   encoding and the default payload width.
package data_skid_pkg;

  // Occupancy of the two-entry stage: no word, one word in main,
  // or main plus an extra word parked in skid.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

  localparam int DATA_SKID_WIDTH = 32;

endpackage

// File: rtl/data_skid_stage.sv
// data_skid_stage
//   Two-entry valid/ready pipeline stage. Both handshake outputs come
//   straight from flops, so out_ready never reaches in_ready through
//   logic. A word accepted while the consumer stalls is parked in the
//   skid register. When the consumer frees main, that word moves into main.
//
// Optional feature: define DATA_SKID_STATS_EN to add xfer_count, a
//   wrapping count of completed output transfers.
//
// Parameters:
//   WIDTH      payload width in bits (1..1024)
//   CNT_W      xfer_count width (only meaningful with DATA_SKID_STATS_EN)
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   upstream word valid
//   in_ready   stage can accept a word this cycle
//   in_data    upstream payload
//   out_valid  out_data holds a valid word
//   out_ready  consumer takes out_data this cycle
//   out_data   payload to the consumer
//   xfer_count completed output transfers (DATA_SKID_STATS_EN only)
module data_skid_stage
  import data_skid_pkg::*;
#(
  parameter int WIDTH = DATA_SKID_WIDTH,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef DATA_SKID_STATS_EN
  ,
  output logic [CNT_W-1:0] xfer_count
`endif
);

  skid_state_t      state;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             in_fire;
  logic             out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign out_data = main_q;

  // in_ready and out_valid are registered copies of the decode of the
  // next state. in_ready stays low through reset. It rises on the first
  // clock edge after reset is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          in_ready <= 1'b1;
          if (in_fire) begin
            main_q    <= in_data;
            state     <= ONE;
            out_valid <= 1'b1;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_q <= in_data;
          end else if (in_fire) begin
            skid_q   <= in_data;
            state    <= FULL;
            in_ready <= 1'b0;
          end else if (out_fire) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_q   <= skid_q;
            state    <= ONE;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state     <= EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef DATA_SKID_STATS_EN
  // Counts output transfers. It wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_count <= '0;
    end else if (out_fire) begin
      xfer_count <= xfer_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_data_skid_stage.sv
// tb_data_skid_stage
//   Directed bench for data_skid_stage. Each word the bench hands to the
//   stage is queued as the expected output. A monitor pops the queue on
//   every output transfer and compares the values, so it runs separately
//   from the stimulus. Directed checks cover reset, latency, back-pressure
//   and a WIDTH=10 instance. With DATA_SKID_STATS_EN, the 32-bit instance
//   uses CNT_W=4.
module tb_data_skid_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data, out_data;
`ifdef DATA_SKID_STATS_EN
  logic [3:0]  xfer_count;
`endif

  logic        in_valid10, in_ready10, out_valid10, out_ready10;
  logic [9:0]  in_data10, out_data10;

  int          testsRun = 0;
  int          testsFailed = 0;
  logic [31:0] expQ[$];

  always #5 clk = ~clk;

  data_skid_stage #(
    .WIDTH(32),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data)
`ifdef DATA_SKID_STATS_EN
    ,
    .xfer_count(xfer_count)
`endif
  );

  data_skid_stage #(
    .WIDTH(10),
    .CNT_W(4)
  ) dut10 (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid10),
    .in_ready(in_ready10),
    .in_data(in_data10),
    .out_valid(out_valid10),
    .out_ready(out_ready10),
    .out_data(out_data10)
`ifdef DATA_SKID_STATS_EN
    ,
    .xfer_count()
`endif
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Holds the word on the input until the stage takes it. The task returns
  // 1 ns after the accepting edge with in_valid still high. This lets a
  // following call continue the stream with no gap.
  task automatic applyStimulus(input logic [31:0] d, output int waits);
    bit accepted = 0;
    waits    = 0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 50 && !accepted; i++) begin
      @(negedge clk);
      if (in_ready) accepted = 1;
      else waits++;
      @(posedge clk);
      #1;
    end
    if (accepted) begin
      expQ.push_back(d);
    end else begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL accept_timeout: word 0x%0h not accepted, required within 50 cycles", d);
    end
  endtask

  // Scoreboard monitor: an output transfer happens at the next rising edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (expQ.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL scoreboard_unexpected: got 0x%0h, required no output", out_data);
      end else begin
        checkOutput("scoreboard", out_data, expQ.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int w;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    out_ready   = 1'b0;
    in_valid10  = 1'b0;
    in_data10   = '0;
    out_ready10 = 1'b0;

    // Reset state while rst_n is low.
    #12;
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_in_ready", in_ready, 0);
    checkOutput("reset_out_data", out_data, 0);
`ifdef DATA_SKID_STATS_EN
    checkOutput("reset_xfer_count", xfer_count, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("first_edge_in_ready", in_ready, 1);

    // A single word appears exactly one cycle after it is accepted.
    out_ready = 1'b1;
    applyStimulus(32'h5, w);
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("latency_out_valid", out_valid, 1);
    checkOutput("latency_out_data", out_data, 32'h5);
    @(negedge clk);
    checkOutput("latency_out_valid_drop", out_valid, 0);

    // The WIDTH=10 instance must keep all 10 bits.
    @(posedge clk);
    #1;
    out_ready10 = 1'b1;
    in_valid10  = 1'b1;
    in_data10   = 10'h3FF;
    @(posedge clk);
    #1;
    in_data10 = 10'h2AA;
    @(negedge clk);
    checkOutput("w10_valid", out_valid10, 1);
    checkOutput("w10_data_3ff", out_data10, 10'h3FF);
    @(posedge clk);
    #1;
    in_valid10 = 1'b0;
    @(negedge clk);
    checkOutput("w10_data_2aa", out_data10, 10'h2AA);

    // Back-to-back stream 1..8: no stall on input, consecutive outputs.
    @(posedge clk);
    #1;
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(i, w);
      checkOutput("stream_in_ready_waits", w, 0);
    end
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("stream_last_valid", out_valid, 1);
    checkOutput("stream_last_data", out_data, 32'h8);
    @(negedge clk);
    checkOutput("stream_drained", out_valid, 0);

    // Back-pressure: A then B fill the stage; A holds until released.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    applyStimulus(32'hA, w);
    applyStimulus(32'hB, w);
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("full_in_ready", in_ready, 0);
    checkOutput("full_out_valid", out_valid, 1);
    checkOutput("full_out_data", out_data, 32'hA);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("stall_hold_data", out_data, 32'hA);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("release_first", out_data, 32'hA);
    @(negedge clk);
    checkOutput("release_second", out_data, 32'hB);
    checkOutput("release_in_ready", in_ready, 1);
    @(negedge clk);
    checkOutput("release_empty", out_valid, 0);

    // Mid-stream reset while FULL discards both words at once.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    applyStimulus(32'hC, w);
    applyStimulus(32'hD, w);
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("prereset_full", in_ready, 0);
    #2;
    rst_n = 1'b0;
    expQ.delete();
    #1;
    checkOutput("async_reset_out_valid", out_valid, 0);
    checkOutput("async_reset_in_ready", in_ready, 0);
    checkOutput("async_reset_out_data", out_data, 0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("no_stale_word", out_valid, 0);
    end
    checkOutput("post_reset_in_ready", in_ready, 1);
`ifdef DATA_SKID_STATS_EN
    checkOutput("post_reset_xfer_count", xfer_count, 0);
`endif

    // Seventeen transfers (the counter wraps when CNT_W=4).
    @(posedge clk);
    #1;
    for (int i = 1; i <= 17; i++) begin
      applyStimulus(32'h100 + i, w);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 20 && expQ.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    checkOutput("final_queue_empty", expQ.size(), 0);
    checkOutput("final_out_valid", out_valid, 0);
`ifdef DATA_SKID_STATS_EN
    checkOutput("xfer_count_wrap", xfer_count, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
